// File: rtl/muldiv_arb_if.sv
// Issue-side bundle between the issue lanes and the shared multiply/divide unit.
interface muldiv_arb_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                   flush;
  logic [LANES-1:0]       req;
  logic [2*LANES-1:0]     op;
  logic [WIDTH*LANES-1:0] srca;
  logic [WIDTH*LANES-1:0] srcb;
  logic [LANES-1:0]       grant;
  logic                   busy;
  logic                   done;
  logic [LW-1:0]          done_lane;
  logic [WIDTH-1:0]       hi;
  logic [WIDTH-1:0]       lo;

  modport master (
    output flush, req, op, srca, srcb,
    input  grant, busy, done, done_lane, hi, lo
  );

  modport slave (
    input  flush, req, op, srca, srcb,
    output grant, busy, done, done_lane, hi, lo
  );
endinterface

// File: rtl/muldiv_arb.sv
// Multi-lane arbitrated MIPS-style MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Fixed-priority arbitration (highest lane wins); restoring divide, one quotient bit per cycle.
module muldiv_arb #(
  parameter int unsigned LANES   = 2,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input logic         clk,
  input logic         resetn,
  muldiv_arb_if.slave bus
);
  localparam int unsigned   LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned   CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MulLast = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CW-1:0] DivLast = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [LW-1:0]    r_lane, w_sel;
  logic             r_sgn, r_neg_q, r_neg_r;
  // Multiply: raw operands. Divide: r_opa is dividend magnitude, then shifts into the quotient.
  logic [WIDTH-1:0] r_opa, r_opb, r_rem, r_hi, r_lo;

  logic             w_any_req, w_grant_en;
  logic [1:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a, w_sel_b;

  always_comb begin
    w_sel     = '0;
    w_any_req = 1'b0;
    w_sel_op  = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.req[i]) begin
        w_sel     = LW'(i);
        w_any_req = 1'b1;
        w_sel_op  = bus.op[2*i +: 2];
        w_sel_a   = bus.srca[i*WIDTH +: WIDTH];
        w_sel_b   = bus.srcb[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_grant_en = resetn && !bus.flush && w_any_req &&
                      ((r_state == StIdle) || (r_state == StDone));

  always_comb begin
    bus.grant = '0;
    if (w_grant_en) bus.grant[w_sel] = 1'b1;
  end

  // Multiply datapath; with MUL_LAT == 1 the product is taken straight from the granted lane.
  logic                    w_mul_sgn;
  logic [WIDTH-1:0]        w_mul_a, w_mul_b;
  logic signed [2*WIDTH-1:0] w_ma, w_mb, w_prod;

  assign w_mul_sgn = (MUL_LAT == 1) ? ~w_sel_op[0] : r_sgn;
  assign w_mul_a   = (MUL_LAT == 1) ? w_sel_a : r_opa;
  assign w_mul_b   = (MUL_LAT == 1) ? w_sel_b : r_opb;
  assign w_ma      = {{WIDTH{w_mul_sgn & w_mul_a[WIDTH-1]}}, w_mul_a};
  assign w_mb      = {{WIDTH{w_mul_sgn & w_mul_b[WIDTH-1]}}, w_mul_b};
  assign w_prod    = w_ma * w_mb;

  // Divide datapath: operand magnitudes at grant, one restoring step per cycle.
  logic             w_neg_a, w_neg_b, w_qbit;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_rem_nx, w_quo_nx, w_div_hi, w_div_lo;
  logic [WIDTH:0]   w_shift, w_trial;

  assign w_neg_a  = ~w_sel_op[0] & w_sel_a[WIDTH-1];
  assign w_neg_b  = ~w_sel_op[0] & w_sel_b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -w_sel_a : w_sel_a;
  assign w_mag_b  = w_neg_b ? -w_sel_b : w_sel_b;
  assign w_shift  = {r_rem, r_opa[WIDTH-1]};
  assign w_trial  = w_shift - {1'b0, r_opb};
  assign w_qbit   = ~w_trial[WIDTH];
  assign w_rem_nx = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nx = {r_opa[WIDTH-2:0], w_qbit};
  assign w_div_lo = r_neg_q ? -w_quo_nx : w_quo_nx;
  assign w_div_hi = r_neg_r ? -w_rem_nx : w_rem_nx;

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (w_grant_en) begin
          if (w_sel_op[1])       w_state_nx = StDiv;
          else if (MUL_LAT == 1) w_state_nx = StDone;
          else                   w_state_nx = StMul;
        end else begin
          w_state_nx = StIdle;
        end
      end
      StMul: begin
        if (bus.flush)             w_state_nx = StIdle;
        else if (r_cnt == MulLast) w_state_nx = StDone;
      end
      StDiv: begin
        if (bus.flush)             w_state_nx = StIdle;
        else if (r_cnt == DivLast) w_state_nx = StDone;
      end
      default: w_state_nx = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_lane  <= '0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_rem   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nx;
      unique case (r_state)
        StIdle, StDone: begin
          if (w_grant_en) begin
            r_lane  <= w_sel;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_sgn   <= ~w_sel_op[0];
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            r_opa   <= w_sel_op[1] ? w_mag_a : w_sel_a;
            r_opb   <= w_sel_op[1] ? w_mag_b : w_sel_b;
            if (!w_sel_op[1] && (MUL_LAT == 1)) begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        StMul: begin
          if (bus.flush || (r_cnt == MulLast)) r_cnt <= '0;
          else                                 r_cnt <= r_cnt + CW'(1);
          if (!bus.flush && (r_cnt == MulLast)) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        StDiv: begin
          if (bus.flush || (r_cnt == DivLast)) r_cnt <= '0;
          else                                 r_cnt <= r_cnt + CW'(1);
          if (!bus.flush) begin
            r_rem <= w_rem_nx;
            r_opa <= w_quo_nx;
            if (r_cnt == DivLast) begin
              r_hi <= w_div_hi;
              r_lo <= w_div_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state == StMul) || (r_state == StDiv);
  assign bus.done      = (r_state == StDone);
  assign bus.done_lane = r_lane;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
endmodule

// File: doc/muldiv_arb.md
MULDIV_ARB -- requirements
Module: muldiv_arb

Interface
REQ-001 SHALL have parameter LANES, default 2: number of issue lanes sharing the unit (2..4).
REQ-002 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-003 SHALL have parameter MUL_LAT, default 2: multiply latency in cycles from grant to done (1..4).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port flush, input, 1: abort the in-flight operation and suppress grant.
REQ-007 SHALL have port req, input, LANES: per-lane operation request.
REQ-008 SHALL have port op, input, 2*LANES: per-lane opcode; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-009 SHALL have ports srca and srcb, input, WIDTH*LANES each: per-lane operands (rs, rt).
REQ-010 SHALL have port grant, output, LANES: one-hot or zero; the lane accepted this cycle.
REQ-011 SHALL have port busy, output, 1: an operation is in flight.
REQ-012 SHALL have port done, output, 1: single-cycle pulse; hi/lo hold the new result.
REQ-013 SHALL have port done_lane, output, clog2(LANES): lane index of the completed operation; valid when done=1.
REQ-014 SHALL have ports hi and lo, output, WIDTH each: architectural HI/LO result registers.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-016 SHALL assert grant only in IDLE or DONE, with flush=0 and at least one req.
- Highest-index requesting lane wins (fixed priority).
- Operands and op of that lane are captured on the same edge.
REQ-017 SHALL transition to MUL on a granted MULT/MULTU and to DIV on a granted DIV/DIVU.
- Otherwise DONE goes to IDLE, and IDLE stays in IDLE.
REQ-018 SHALL compute the multiply as a 2*WIDTH product.
- Signed for MULT, unsigned for MULTU.
- hi = upper WIDTH bits, lo = lower WIDTH bits.
- done is asserted exactly MUL_LAT cycles after the grant cycle.
REQ-019 SHALL compute the divide as a radix-2 restoring divide on magnitudes, one quotient bit per cycle.
- WIDTH iterations.
- done is asserted exactly WIDTH+1 cycles after the grant cycle.
REQ-020 SHALL produce lo = quotient and hi = remainder.
- Signed DIV: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
REQ-021 SHALL handle signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-022 SHALL handle divide by zero deterministically.
- Result is lo = all-ones and hi = dividend magnitude, with the signed fix-up applied.
- Latency is unchanged.
REQ-023 SHALL update hi/lo only on the edge entering DONE; done=1 and done_lane are valid for exactly the DONE cycle.
REQ-024 SHALL drive busy=1 in MUL and DIV, and busy=0 in IDLE and DONE.
REQ-025 SHALL, on flush in MUL or DIV, return to IDLE on the next edge.
- No done is produced.
- hi/lo are unchanged.
- Iteration/latency counters are cleared.
REQ-026 SHALL, on flush in IDLE/DONE with req asserted, suppress grant.
- A DONE cycle coinciding with flush still completes: hi/lo are already updated and done=1.
REQ-027 SHALL allow back-to-back operation: a grant in the DONE cycle starts the next op with no idle gap.
REQ-028 SHALL ignore req while busy=1; requesters hold req until granted.

Reset
REQ-029 SHALL, on resetn=0, asynchronously set state=IDLE, hi=0, lo=0, grant=0, busy=0, done=0, done_lane=0, and clear all counters.
REQ-030 SHALL, on reset mid-operation, discard the operation with no done after release.
REQ-031 SHALL be able to grant in the first cycle after resetn deasserts.

Verification
REQ-032 SHALL verify a MULT conflict.
- Stimulus: lane0 MULT 0xFFFFFFFF x 0x00000002 and lane1 MULTU 3 x 5 in the same cycle.
- Response: grant=0b10; done after MUL_LAT cycles with done_lane=1, hi=0, lo=15.
- Then lane0 is granted and gives hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-033 SHALL verify signed DIV.
- Stimulus: DIV -7 / 2.
- Response: done at grant+33 (WIDTH=32); lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-034 SHALL verify DIV overflow and divide by zero.
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU 9 / 0 gives lo=0xFFFFFFFF, hi=9.
REQ-035 SHALL verify flush abort.
- Stimulus: flush 10 cycles into DIVU 100 / 7 with prior hi/lo = 0x1234/0x5678.
- Response: no done, hi/lo unchanged, busy=0 the next cycle, grant possible the cycle after.
REQ-036 SHALL verify back-to-back operation and reset.
- A req held through the DONE cycle is granted in that DONE cycle.
- resetn pulsed low mid-MUL clears hi/lo to 0 with no done.
